// File: rtl/huffman_bitstream_packer.sv
// Walks the data RAM, looks up each byte's Huffman code and packs the codes MSB-first
// into a byte stream on a valid/ready port, zero-padding the final partial byte.
module huffman_bitstream_packer #(
  parameter int DATA_DEPTH = 102400,
  parameter int ADDR_W     = 17,
  parameter int LEN_MAX    = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              data_en,
  output logic [ADDR_W-1:0] data_addr,
  input  logic [7:0]        data_q,
  output logic              enc_en,
  output logic [7:0]        enc_addr,
  input  logic [31:0]       enc_q,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       bit_count,
  output logic [31:0]       byte_count,
  output logic [2:0]        state_dbg
);

  // Handshake: a byte transfers on any rising edge where tx_valid && tx_ready.
  // tx_valid is a function of state/fill only; once high it and tx_data hold until taken.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_DATA = 3'd1,
    S_RD_CODE = 3'd2,
    S_LOAD    = 3'd3,
    S_EMIT    = 3'd4,
    S_FLUSH   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       acc;
  logic [5:0]        fill;
  logic              err_q;
  logic [31:0]       bit_cnt_q, byte_cnt_q;

  logic [7:0]  code_len;
  logic        len_ok;
  logic [31:0] code_mask;
  logic        last_sym;
  logic        hs;
  logic [5:0]  fill_after;
  logic [31:0] emit_shift, flush_shift;

  assign code_len    = enc_q[31:24];
  assign len_ok      = (code_len != 8'd0) && (code_len <= 8'(LEN_MAX));
  assign code_mask   = (32'h1 << code_len) - 32'h1;
  assign last_sym    = (idx == ADDR_W'(DATA_DEPTH - 1));
  assign hs          = tx_valid && tx_ready;
  assign fill_after  = hs ? (fill - 6'd8) : fill;
  assign emit_shift  = acc >> (fill - 6'd8);
  assign flush_shift = acc << (6'd8 - fill);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // EMIT looks at the post-handshake fill so the symbol advances on the same cycle
  // the last full byte leaves; done then follows the final handshake by one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_RD_DATA;
      S_RD_DATA: state_nxt = S_RD_CODE;
      S_RD_CODE: state_nxt = S_LOAD;
      S_LOAD:    state_nxt = len_ok ? S_EMIT : S_DONE;
      S_EMIT: begin
        if (fill_after < 6'd8) begin
          if (!last_sym)                state_nxt = S_RD_DATA;
          else if (fill_after == 6'd0)  state_nxt = S_DONE;
          else                          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH:   if (fill == 6'd0 || hs) state_nxt = S_DONE;
      S_DONE:    if (!start) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    data_en   = (state == S_RD_DATA);
    data_addr = (state == S_RD_DATA) ? idx : '0;
    enc_en    = (state == S_RD_CODE);
    enc_addr  = (state == S_RD_CODE) ? data_q : 8'd0;
    tx_valid  = 1'b0;
    tx_data   = 8'd0;
    if (state == S_EMIT && fill >= 6'd8) begin
      tx_valid = 1'b1;
      tx_data  = emit_shift[7:0];
    end else if (state == S_FLUSH && fill != 6'd0) begin
      tx_valid = 1'b1;
      tx_data  = flush_shift[7:0];
    end
    busy       = (state != S_IDLE) && (state != S_DONE);
    done       = (state == S_DONE);
    err        = err_q;
    bit_count  = bit_cnt_q;
    byte_count = byte_cnt_q;
    state_dbg  = state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= '0;
      acc        <= 32'd0;
      fill       <= 6'd0;
      err_q      <= 1'b0;
      bit_cnt_q  <= 32'd0;
      byte_cnt_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx        <= '0;
            acc        <= 32'd0;
            fill       <= 6'd0;
            err_q      <= 1'b0;
            bit_cnt_q  <= 32'd0;
            byte_cnt_q <= 32'd0;
          end
        end
        S_LOAD: begin
          if (len_ok) begin
            acc       <= (acc << code_len) | (enc_q & code_mask);
            fill      <= fill + code_len[5:0];
            bit_cnt_q <= bit_cnt_q + {24'd0, code_len};
          end else begin
            err_q <= 1'b1;
          end
        end
        S_EMIT: begin
          if (hs) begin
            fill       <= fill - 6'd8;
            byte_cnt_q <= byte_cnt_q + 32'd1;
          end
          if (fill_after < 6'd8 && !last_sym) idx <= idx + ADDR_W'(1);
        end
        S_FLUSH: begin
          if (hs) begin
            fill       <= 6'd0;
            byte_cnt_q <= byte_cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
